// File: rtl/acc_trace_fifo_if.sv
// ============================================================================
// Module   : acc_trace_fifo_if
// Brief    : Valid/ready drain port carrying {timestamp, cy, z, ACC} entries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface acc_trace_fifo_if #(
    parameter int TS_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [TS_W+9:0]   out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/acc_trace_fifo.sv
// ============================================================================
// Module   : acc_trace_fifo
// Brief    : Logs time-stamped changes of the core's {cy,z,ACC} into a FWFT
//            FIFO drained over a valid/ready port. Optional macro
//            TRACE_DROP_CNT_EN adds a saturating 8-bit drop counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                ACC,
    input  logic                      z,
    input  logic                      cy,
    input  logic                      en,
    acc_trace_fifo_if.master          out_if,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    input  logic                      clr_ovf
`ifdef TRACE_DROP_CNT_EN
    ,
    output logic [7:0]                drop_cnt
`endif
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam int               c_CW   = c_AW + 1;
    localparam int               c_EW   = TS_W + 10;
    localparam logic [c_CW-1:0]  c_FULL = c_CW'(DEPTH);

    logic [TS_W-1:0]  r_ts;
    logic [9:0]       r_prev;
    logic             r_first;
    logic [c_EW-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_overflow;

    logic [9:0]       w_cur;
    logic             w_change;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_cur    = {cy, z, ACC};
    assign w_change = en & (r_first | (w_cur != r_prev));
    assign w_full   = (r_count == c_FULL);
    assign w_empty  = (r_count == '0);
    assign w_pop    = ~w_empty & out_if.out_ready;
    // A pop in the same cycle frees the slot the new sample needs.
    assign w_push   = w_change & (~w_full | w_pop);
    assign w_drop   = w_change & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev  <= '0;
            r_first <= 1'b1;
        end else if (en) begin
            r_prev  <= w_cur;
            r_first <= 1'b0;
        end else begin
            r_first <= 1'b1;
        end
    end

    // Storage needs no reset: nothing is read until the count says so.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_ts, w_cur};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef TRACE_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (clr_ovf) begin
            r_drop_cnt <= {7'd0, w_drop};
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign out_if.out_valid = ~w_empty;
    assign out_if.out_data  = r_mem[r_rd_ptr];
    assign count            = r_count;
    assign overflow         = r_overflow;

endmodule

`default_nettype wire

// File: doc/acc_trace_fifo.md
Name: acc_trace_fifo

Overview:
- Downstream observer of the multi-cycle 8085 core. Samples the core's ACC, z and cy outputs every clock.
- Detects changes in the 10-bit state {cy,z,ACC}. Each change is time-stamped with a free-running cycle counter and pushed into a small FIFO.
- A valid/ready port drains the FIFO to a debug host or display consumer.
- Lets the bench and board observe program progress without probing internal datapath registers.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64.
TS_W, 8, timestamp counter width in bits.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
ACC  input  8  core accumulator value.
z  input  1  core zero flag.
cy  input  1  core carry flag.
en  input  1  trace enable.
out_valid  output  1  FIFO head entry valid.
out_ready  input  1  consumer accepts the head entry.
out_data  output  TS_W+10  head entry, packed as {timestamp, cy, z, ACC}.
count  output  log2(DEPTH)+1  current occupancy.
overflow  output  1  sticky flag: a sample was dropped.
clr_ovf  input  1  synchronous clear of overflow (and drop_cnt when present).

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, count=0, out_valid=0, overflow=0.
  - Timestamp ts=0, prev={cy,z,ACC} register=0, first flag=1.
  - out_data is don't-care while out_valid=0.
- Timestamp:
  - ts increments by 1 on every clk edge out of reset, independent of en.
  - Wraps from 2^TS_W-1 to 0.
  - The value stored in an entry is ts as seen in the cycle the sample is taken, before the edge.
- Change detect, per cycle:
  - cur={cy,z,ACC}.
  - change = en & (first | cur!=prev).
  - When en=1: prev<=cur and first<=0 at the edge.
  - When en=0: prev held and first<=1, so the first enabled cycle after a disable always logs.
- Push: on change, write {ts,cur} at the tail if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Drop: on change with FIFO full and no same-cycle pop, the sample is discarded and overflow<=1 at the edge.
- Pop: out_valid & out_ready removes the head at the edge. out_ready while empty has no effect.
- Simultaneous push and pop: count unchanged. When the FIFO is empty, a push plus out_ready does not bypass; the entry appears next cycle.
- FIFO type: first-word-fall-through. out_valid = (count!=0) and out_data = head entry, both directly from registers.
- Latency: a change sampled before edge k gives out_valid=1 after edge k when the FIFO was empty (1 cycle).
- Pointers: read/write pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Overflow clear: clr_ovf=1 clears overflow at the edge. If a drop occurs in the same cycle, set wins (overflow stays 1).
- Reset mid-operation: all queued entries are lost and the state returns to reset values.
- Inputs ACC/z/cy are synchronous to clk and come from core registers, so no synchronizer is required.

Optional Feature:
- Macro: TRACE_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt (8 bits), reset 0.
  - Increments by 1 on each dropped sample and saturates at 255.
  - clr_ovf clears it to 0. If clr_ovf and a drop occur in the same cycle, the result is 1.
- Not defined: drop_cnt port and logic are absent; only the sticky overflow reports loss.

Test Plan:
- Reset then en=1, ACC=0x00, z=1, cy=0 held, out_ready=0:
  - exactly one entry {ts=0 (first enabled cycle), cy=0, z=1, ACC=0x00}.
  - count=1, no further pushes while inputs are steady.
- ACC sequence 0x05,0x05,0x0A over cycles 3..5, out_ready=1:
  - entries for 0x05 (ts=3) and 0x0A (ts=5) only.
  - each has out_valid high for one cycle, starting 1 cycle after its sample.
- DEPTH=8, out_ready=0, ACC changes for 10 consecutive cycles:
  - count=8, first 8 values kept in order, last 2 dropped, overflow=1.
  - with TRACE_DROP_CNT_EN, drop_cnt=2.
- FIFO full, out_ready=1 and a change in the same cycle:
  - the head is popped, the new sample accepted, count stays 8, overflow stays 0.
- TS_W=4, changes at cycles 14 and 17:
  - timestamps 14 and 1 (wrap verified).
- Reset deasserted with queued entries, then reset=0 asserted asynchronously mid-cycle:
  - out_valid=0 and count=0 immediately, overflow=0.
  - after release, next enabled cycle logs with ts=0.
